// File: rtl/river_mem_arbiter.sv
// Round-robin arbiter funnelling several RiverTop memory ports onto one bus port.
// One transaction in flight at a time: IDLE -> REQ -> RESP -> IDLE.

module river_mem_arbiter_lane (
  input  logic sel,
  input  logic in_req,
  input  logic in_resp,
  input  logic bus_req_ready,
  input  logic bus_resp_valid,
  output logic req_ready,
  output logic resp_valid
);
  assign req_ready  = sel & in_req  & bus_req_ready;
  assign resp_valid = sel & in_resp & bus_resp_valid;
endmodule

module river_mem_arbiter #(
  parameter int cpu_total = 2,
  parameter int addr_bits = 48,
  parameter int line_bits = 256
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic [cpu_total-1:0]                     i_req_valid,
  input  logic [cpu_total-1:0]                     i_req_path,
  input  logic [cpu_total-1:0][2:0]                i_req_type,
  input  logic [cpu_total-1:0][2:0]                i_req_size,
  input  logic [cpu_total-1:0][addr_bits-1:0]      i_req_addr,
  input  logic [cpu_total-1:0][line_bits/8-1:0]    i_req_strob,
  input  logic [cpu_total-1:0][line_bits-1:0]      i_req_data,
  output logic [cpu_total-1:0]                     o_req_ready,
  output logic [cpu_total-1:0]                     o_resp_valid,
  output logic                                     o_resp_path,
  output logic [line_bits-1:0]                     o_resp_data,
  output logic                                     o_resp_load_fault,
  output logic                                     o_resp_store_fault,
  input  logic                                     i_bus_req_ready,
  output logic                                     o_bus_req_valid,
  output logic                                     o_bus_req_path,
  output logic [2:0]                               o_bus_req_type,
  output logic [2:0]                               o_bus_req_size,
  output logic [addr_bits-1:0]                     o_bus_req_addr,
  output logic [line_bits/8-1:0]                   o_bus_req_strob,
  output logic [line_bits-1:0]                     o_bus_req_data,
  output logic [1:0]                               o_bus_req_id,
  input  logic                                     i_bus_resp_valid,
  input  logic                                     i_bus_resp_path,
  input  logic [line_bits-1:0]                     i_bus_resp_data,
  input  logic                                     i_bus_resp_load_fault,
  input  logic                                     i_bus_resp_store_fault
);
  localparam int GW = (cpu_total > 2) ? 2 : 1;
  localparam logic [GW-1:0] LAST = GW'(cpu_total - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic                   path;
    logic [2:0]             rtype;
    logic [2:0]             size;
    logic [addr_bits-1:0]   addr;
    logic [line_bits/8-1:0] strob;
    logic [line_bits-1:0]   data;
  } req_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] rr_ptr, rr_nxt;
  logic [GW-1:0] pick;
  logic          found;
  req_t          req_lane [cpu_total];
  req_t          req_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Scan requesters starting at rr_ptr, wrapping past the last CPU.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < cpu_total; k++) begin
      logic [GW:0] idx;
      idx = {1'b0, rr_ptr} + (GW+1)'(k);
      if (idx >= (GW+1)'(cpu_total))
        idx = idx - (GW+1)'(cpu_total);
      if (!found && i_req_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // A bus accept wins over a same-cycle withdrawal: the bus now owns it.
        if (i_bus_req_ready) begin
          state_nxt = RESP;
          rr_nxt    = (grant == LAST) ? '0 : grant + GW'(1);
        end else if (!i_req_valid[grant]) begin
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (i_bus_resp_valid)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < cpu_total; i++) begin : g_lane
    assign req_lane[i] = '{path: i_req_path[i], rtype: i_req_type[i], size: i_req_size[i],
                           addr: i_req_addr[i], strob: i_req_strob[i], data: i_req_data[i]};
    river_mem_arbiter_lane u_lane (
      .sel            (grant == GW'(i)),
      .in_req         (state == REQ),
      .in_resp        (state == RESP),
      .bus_req_ready  (i_bus_req_ready),
      .bus_resp_valid (i_bus_resp_valid),
      .req_ready      (o_req_ready[i]),
      .resp_valid     (o_resp_valid[i])
    );
  end

  assign req_sel         = req_lane[grant];
  assign o_bus_req_valid = (state == REQ);
  assign o_bus_req_path  = req_sel.path;
  assign o_bus_req_type  = req_sel.rtype;
  assign o_bus_req_size  = req_sel.size;
  assign o_bus_req_addr  = req_sel.addr;
  assign o_bus_req_strob = req_sel.strob;
  assign o_bus_req_data  = req_sel.data;
  assign o_bus_req_id    = 2'(grant);

  // Faults only mean something alongside a delivered response.
  assign o_resp_path        = i_bus_resp_path;
  assign o_resp_data        = i_bus_resp_data;
  assign o_resp_load_fault  = (state == RESP) & i_bus_resp_valid & i_bus_resp_load_fault;
  assign o_resp_store_fault = (state == RESP) & i_bus_resp_valid & i_bus_resp_store_fault;
endmodule

// File: tb/tb_river_mem_arbiter.sv
// Directed bench for river_mem_arbiter with two CPUs: grant order, stalls,
// withdrawal, fault gating and reset behaviour.

module tb_river_mem_arbiter;
  localparam int NC = 2;
  localparam int AW = 48;
  localparam int LW = 256;

  logic                          i_clk = 1'b0;
  logic                          i_rst;
  logic [NC-1:0]                 i_req_valid;
  logic [NC-1:0]                 i_req_path;
  logic [NC-1:0][2:0]            i_req_type;
  logic [NC-1:0][2:0]            i_req_size;
  logic [NC-1:0][AW-1:0]         i_req_addr;
  logic [NC-1:0][LW/8-1:0]       i_req_strob;
  logic [NC-1:0][LW-1:0]         i_req_data;
  logic [NC-1:0]                 o_req_ready;
  logic [NC-1:0]                 o_resp_valid;
  logic                          o_resp_path;
  logic [LW-1:0]                 o_resp_data;
  logic                          o_resp_load_fault;
  logic                          o_resp_store_fault;
  logic                          i_bus_req_ready;
  logic                          o_bus_req_valid;
  logic                          o_bus_req_path;
  logic [2:0]                    o_bus_req_type;
  logic [2:0]                    o_bus_req_size;
  logic [AW-1:0]                 o_bus_req_addr;
  logic [LW/8-1:0]               o_bus_req_strob;
  logic [LW-1:0]                 o_bus_req_data;
  logic [1:0]                    o_bus_req_id;
  logic                          i_bus_resp_valid;
  logic                          i_bus_resp_path;
  logic [LW-1:0]                 i_bus_resp_data;
  logic                          i_bus_resp_load_fault;
  logic                          i_bus_resp_store_fault;

  int checks = 0;
  int errors = 0;

  river_mem_arbiter #(.cpu_total(NC), .addr_bits(AW), .line_bits(LW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_path(i_req_path), .i_req_type(i_req_type),
    .i_req_size(i_req_size), .i_req_addr(i_req_addr), .i_req_strob(i_req_strob),
    .i_req_data(i_req_data), .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid),
    .o_resp_path(o_resp_path), .o_resp_data(o_resp_data),
    .o_resp_load_fault(o_resp_load_fault), .o_resp_store_fault(o_resp_store_fault),
    .i_bus_req_ready(i_bus_req_ready), .o_bus_req_valid(o_bus_req_valid),
    .o_bus_req_path(o_bus_req_path), .o_bus_req_type(o_bus_req_type),
    .o_bus_req_size(o_bus_req_size), .o_bus_req_addr(o_bus_req_addr),
    .o_bus_req_strob(o_bus_req_strob), .o_bus_req_data(o_bus_req_data),
    .o_bus_req_id(o_bus_req_id), .i_bus_resp_valid(i_bus_resp_valid),
    .i_bus_resp_path(i_bus_resp_path), .i_bus_resp_data(i_bus_resp_data),
    .i_bus_resp_load_fault(i_bus_resp_load_fault),
    .i_bus_resp_store_fault(i_bus_resp_store_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [AW-1:0] A0 = 48'h0000_4000_0040;
  localparam logic [AW-1:0] A1 = 48'h0000_8000_1000;
  localparam logic [LW-1:0] D0 = {8{32'h0D0D_0000}};
  localparam logic [LW-1:0] D1 = {8{32'hD1D1_1111}};
  localparam logic [LW-1:0] R1 = {8{32'hCAFE_0001}};

  initial begin
    logic [1:0]    exp_id [4];
    logic [AW-1:0] exp_addr;

    i_rst = 1'b1;
    i_req_valid = '0; i_req_path = 2'b10; i_req_type = '0; i_req_size = '0;
    i_req_addr[0] = A0; i_req_addr[1] = A1;
    i_req_strob[0] = 32'h0000_000F; i_req_strob[1] = 32'hFFFF_FFFF;
    i_req_data[0] = D0; i_req_data[1] = D1;
    i_req_size[1] = 3'd5; i_req_type[1] = 3'd1;
    i_bus_req_ready = 1'b0;
    i_bus_resp_valid = 1'b0; i_bus_resp_path = 1'b0; i_bus_resp_data = '0;
    i_bus_resp_load_fault = 1'b0; i_bus_resp_store_fault = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    #1;
    chk("reset_req_ready", LW'(o_req_ready), LW'(2'b00));
    chk("reset_resp_valid", LW'(o_resp_valid), LW'(2'b00));
    chk("reset_bus_valid", LW'(o_bus_req_valid), LW'(1'b0));

    // Single CPU1 read
    i_req_valid = 2'b10;
    #1;
    chk("t1_idle_bus_valid", LW'(o_bus_req_valid), LW'(1'b0));
    tick();
    i_bus_req_ready = 1'b1;
    #1;
    chk("t1_bus_valid", LW'(o_bus_req_valid), LW'(1'b1));
    chk("t1_bus_id", LW'(o_bus_req_id), LW'(2'd1));
    chk("t1_bus_addr", LW'(o_bus_req_addr), LW'(A1));
    chk("t1_bus_data", o_bus_req_data, D1);
    chk("t1_bus_path", LW'(o_bus_req_path), LW'(1'b1));
    chk("t1_bus_size", LW'(o_bus_req_size), LW'(3'd5));
    chk("t1_req_ready", LW'(o_req_ready), LW'(2'b10));
    tick();
    i_bus_req_ready = 1'b0; i_req_valid = 2'b00;
    #1;
    chk("t1_resp_bus_valid", LW'(o_bus_req_valid), LW'(1'b0));
    chk("t1_resp_req_ready", LW'(o_req_ready), LW'(2'b00));
    chk("t1_resp_wait", LW'(o_resp_valid), LW'(2'b00));
    tick();
    i_bus_resp_valid = 1'b1; i_bus_resp_data = R1; i_bus_resp_path = 1'b1;
    #1;
    chk("t1_resp_valid", LW'(o_resp_valid), LW'(2'b10));
    chk("t1_resp_data", o_resp_data, R1);
    chk("t1_resp_path", LW'(o_resp_path), LW'(1'b1));
    tick();
    i_bus_resp_valid = 1'b0;
    #1;
    chk("t1_back_idle", LW'(o_resp_valid), LW'(2'b00));

    // Both CPUs requesting: round robin 0,1,0,1
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd0; exp_id[3] = 2'd1;
    i_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_addr = (exp_id[k] == 2'd0) ? A0 : A1;
      chk("rr_id", LW'(o_bus_req_id), LW'(exp_id[k]));
      chk("rr_addr", LW'(o_bus_req_addr), LW'(exp_addr));
      i_bus_req_ready = 1'b1;
      #1;
      chk("rr_req_ready", LW'(o_req_ready), LW'(2'b01 << exp_id[k]));
      tick();
      i_bus_req_ready = 1'b0; i_bus_resp_valid = 1'b1;
      #1;
      chk("rr_resp_valid", LW'(o_resp_valid), LW'(2'b01 << exp_id[k]));
      tick();
      i_bus_resp_valid = 1'b0;
    end

    // Bus stall for 5 cycles on CPU0; stray response in REQ ignored
    i_req_valid = 2'b01;
    tick();
    i_bus_resp_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", LW'(o_bus_req_valid), LW'(1'b1));
      chk("stall_addr", LW'(o_bus_req_addr), LW'(A0));
      chk("stall_data", o_bus_req_data, D0);
      chk("stall_ready", LW'(o_req_ready), LW'(2'b00));
      chk("stall_resp_ignored", LW'(o_resp_valid), LW'(2'b00));
      tick();
    end
    i_bus_resp_valid = 1'b0;
    i_bus_req_ready = 1'b1;
    #1;
    chk("stall_release", LW'(o_req_ready), LW'(2'b01));
    tick();
    i_bus_req_ready = 1'b0; i_req_valid = 2'b00;

    // Store fault gating in RESP
    i_bus_resp_store_fault = 1'b1;
    #1;
    chk("sf_no_valid", LW'(o_resp_store_fault), LW'(1'b0));
    i_bus_resp_valid = 1'b1;
    #1;
    chk("sf_with_valid", LW'(o_resp_store_fault), LW'(1'b1));
    chk("sf_resp_valid", LW'(o_resp_valid), LW'(2'b01));
    chk("sf_load_fault", LW'(o_resp_load_fault), LW'(1'b0));
    tick();
    #1;
    chk("sf_idle_gated", LW'(o_resp_store_fault), LW'(1'b0));
    chk("sf_idle_resp", LW'(o_resp_valid), LW'(2'b00));
    i_bus_resp_valid = 1'b0; i_bus_resp_store_fault = 1'b0;

    // Reset in RESP, then a late bus response
    i_req_valid = 2'b10;
    tick();
    chk("rst_grant1", LW'(o_bus_req_id), LW'(2'd1));
    i_bus_req_ready = 1'b1;
    tick();
    i_bus_req_ready = 1'b0; i_req_valid = 2'b00; i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_bus_resp_valid = 1'b1;
    #1;
    chk("rst_stray_resp", LW'(o_resp_valid), LW'(2'b00));
    chk("rst_bus_valid", LW'(o_bus_req_valid), LW'(1'b0));
    tick();
    chk("rst_stray_resp2", LW'(o_resp_valid), LW'(2'b00));
    i_bus_resp_valid = 1'b0;

    // CPU0 withdraws in REQ; rr_ptr must stay 0
    i_req_valid = 2'b01;
    tick();
    chk("wd_req_valid", LW'(o_bus_req_valid), LW'(1'b1));
    chk("wd_req_id", LW'(o_bus_req_id), LW'(2'd0));
    i_req_valid = 2'b00;
    #1;
    chk("wd_no_ready", LW'(o_req_ready), LW'(2'b00));
    tick();
    chk("wd_back_idle", LW'(o_bus_req_valid), LW'(1'b0));
    i_req_valid = 2'b11;
    tick();
    chk("wd_rr_kept", LW'(o_bus_req_id), LW'(2'd0));
    i_bus_req_ready = 1'b1;
    tick();
    i_bus_req_ready = 1'b0; i_req_valid = 2'b00; i_bus_resp_valid = 1'b1;
    i_bus_resp_load_fault = 1'b1;
    #1;
    chk("wd_load_fault", LW'(o_resp_load_fault), LW'(1'b1));
    chk("wd_resp_valid", LW'(o_resp_valid), LW'(2'b01));
    tick();
    i_bus_resp_valid = 1'b0; i_bus_resp_load_fault = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
